sw_debounce: RTL

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sw_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sw_debounce: per-bit debouncer for active-low switches, press/release |
// | pulses, sticky IRQ.  Revision: 1.0                                    |
// +-----------------------------------------------------------------------+
module sw_debounce #(
  parameter int Width          = 16,
  parameter int DebounceCycles = 20000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] sw_raw_ni,
  output logic [Width-1:0] sw_o,
  output logic [Width-1:0] press_o,
  output logic [Width-1:0] release_o,
  input  logic             irq_clr_i,
  output logic             irq_o
);

  localparam int              CntW   = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  typedef enum logic [0:0] {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_e;

  // Synchroniser resets to 1 so a released pad looks idle straight out of reset.
  logic [Width-1:0] sync1_q;
  logic [Width-1:0] sync2_q;
  logic [Width-1:0] s_w;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sw_raw_ni;
      sync2_q <= sync1_q;
    end
  end

  assign s_w = ~sync2_q;

  for (genvar i = 0; i < Width; i++) begin : g_bit
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sw_q, sw_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= STABLE;
        cnt_q   <= '0;
        sw_q    <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        sw_q    <= sw_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sw_d    = sw_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        STABLE: begin
          if (s_w[i] != sw_q) begin
            state_d = COUNTING;
            cnt_d   = CntW'(1);
          end else begin
            cnt_d = '0;
          end
        end
        COUNTING: begin
          if (s_w[i] == sw_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CntMax) begin
            // Commit: flip the debounced level and emit the matching edge pulse.
            state_d = STABLE;
            cnt_d   = '0;
            sw_d    = ~sw_q;
            press_d = ~sw_q;
            rel_d   = sw_q;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign sw_o[i]      = sw_q;
    assign press_o[i]   = press_q;
    assign release_o[i] = rel_q;
  end

  logic irq_q, irq_d;
  logic any_pulse_w;

  assign any_pulse_w = (|press_o) | (|release_o);

  // A pulse and a clear in the same cycle leave the flag set.
  always_comb begin
    irq_d = irq_q;
    if (any_pulse_w) begin
      irq_d = 1'b1;
    end else if (irq_clr_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule
`default_nettype wire
